// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and types for the UART transmit path
//
// Holds the data width, the transmit-controller state encoding and the
// default start-acknowledge timeout used by uart_tx_ctrl.
package uart_pkg;

  localparam int DATA_W              = 8;
  localparam int ACK_TIMEOUT_DEFAULT = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2
  } uart_tx_ctrl_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO feeding the transmit sequencer
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   push, push_data   write strobe and byte; accepted when not full or popping
//   pop               removes the head entry (caller only pops when not empty)
//   head              byte at the read pointer, decoded from registered storage
//   full, empty       occupancy flags decoded from the pointers
//   level             current occupancy, 0..DEPTH
//   drop              high in a cycle where a push is discarded (full, no pop)
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              accept;
  logic              do_pop;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level  = wr_ptr_q - rd_ptr_q;
  assign head   = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the slot in the same cycle, so a push into a full FIFO is
  // still accepted when it coincides with a pop.
  assign do_pop = pop && !empty;
  assign accept = push && (!full || do_pop);
  assign drop   = push && full && !do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (accept) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - byte-queueing start/busy/done sequencer for the UART transmitter
//
// Optional feature macro: UART_TX_CTRL_TIMEOUT_EN (start-acknowledge timeout).
//
// Ports:
//   clk, rst_n             system clock, asynchronous active-low reset
//   enable                 launch enable; a frame in flight always completes
//   wr_en, wr_data         byte push from the register slice
//   full, empty, level     FIFO occupancy
//   overflow               sticky, set when a push is dropped
//   clr_status             pulse clearing overflow and timeout_err
//   tx_start, tx_data      registered frame request and byte to the transmitter
//   tx_enable              transmitter enable
//   tx_busy, tx_done       transmitter frame-in-progress / end-of-frame
//   idle                   IDLE state with an empty FIFO
//   timeout_err            sticky start-acknowledge timeout flag
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr_status,
  output logic                   tx_start,
  output logic                   tx_enable,
  output logic [DATA_W-1:0]      tx_data,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic                   idle,
  output logic                   timeout_err
);

  uart_tx_ctrl_state_t state_q, state_d;
  logic                tx_start_q, tx_start_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   head;
  logic                pop;
  logic                drop;
  logic                launch;
  logic                ack_expired;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .drop      (drop)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; launch looks at registered empty, so a byte pushed this
  // cycle cannot be popped until the next one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable && !empty && !tx_busy) state_d = REQ;
      REQ: begin
        if (tx_busy)          state_d = SEND;
        else if (ack_expired) state_d = IDLE;
      end
      SEND: if (tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign launch = (state_q == IDLE) && (state_d == REQ);

  // Output logic
  always_comb begin
    pop        = 1'b0;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    if (launch) begin
      pop        = 1'b1;
      tx_start_d = 1'b1;
      tx_data_d  = head;
    end
    // Leaving REQ for either reason (acknowledged or timed out) ends the request.
    if ((state_q == REQ) && (state_d != REQ)) begin
      tx_start_d = 1'b0;
    end
    // A new event in the same cycle as clr_status keeps the flag set.
    overflow_d = (overflow_q && !clr_status) || drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef UART_TX_CTRL_TIMEOUT_EN
  localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  logic [CW-1:0] ack_cnt_q, ack_cnt_d;
  logic          timeout_err_q, timeout_err_d;

  // REQ lasts at most ACK_TIMEOUT cycles; the popped byte is simply abandoned.
  assign ack_expired = (state_q == REQ) && !tx_busy &&
                       (ack_cnt_q == CW'(ACK_TIMEOUT - 1));

  always_comb begin
    ack_cnt_d = ack_cnt_q;
    if (launch) begin
      ack_cnt_d = '0;
    end else if (state_q == REQ) begin
      ack_cnt_d = ack_cnt_q + 1'b1;
    end
    timeout_err_d = (timeout_err_q && !clr_status) || ack_expired;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      ack_cnt_q     <= ack_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign ack_expired = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign overflow  = overflow_q;
  assign tx_enable = enable || (state_q != IDLE);
  assign idle      = (state_q == IDLE) && empty;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

  localparam int DEPTH   = 8;
  localparam int ACK_TO  = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_status;
  logic       tx_busy;
  logic       tx_done;
  logic       full, empty, overflow, tx_start, tx_enable, idle, timeout_err;
  logic [3:0] level;
  logic [7:0] tx_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Transmitter model state and event log
  bit         model_on = 1'b0;
  bit         active   = 1'b0;
  int         mcnt     = 0;
  logic       prev_start = 1'b0;
  int         busy_rise  = -1;
  int         start_fall = -1;
  int         start_cyc[$];
  logic [7:0] start_data[$];
  int         start_level[$];
  int         done_cyc[$];

  uart_tx_ctrl #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .clr_status  (clr_status),
    .tx_start    (tx_start),
    .tx_enable   (tx_enable),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .idle        (idle),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, then transmitter model: busy 3 cycles after start, done 20 later.
  always @(negedge clk) begin
    if (tx_start && !prev_start) begin
      start_cyc.push_back(cyc);
      start_data.push_back(tx_data);
      start_level.push_back(int'(level));
    end
    if (!tx_start && prev_start) start_fall = cyc;
    prev_start = tx_start;

    tx_done = 1'b0;
    if (!rst_n || !model_on) begin
      active  = 1'b0;
      mcnt    = 0;
      tx_busy = 1'b0;
    end else if (active) begin
      mcnt++;
      if (mcnt == 3) begin
        tx_busy   = 1'b1;
        busy_rise = cyc;
      end
      if (mcnt == 23) begin
        tx_busy = 1'b0;
        tx_done = 1'b1;
        done_cyc.push_back(cyc);
        active  = 1'b0;
      end
    end else if (tx_start) begin
      active = 1'b1;
      mcnt   = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    start_cyc.delete();
    start_data.delete();
    start_level.delete();
    done_cyc.delete();
    busy_rise  = -1;
    start_fall = -1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    enable     = 1'b0;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    clr_status = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_log();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty, full); end
    checks++; if (overflow !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL reset_sticky got ovf=%b to=%b exp 0 0", overflow, timeout_err); end
    checks++; if (tx_enable !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL reset_en_idle got txen=%b idle=%b exp 0 1", tx_enable, idle); end
  endtask

  task automatic test_single();
    int n;
    clear_log();
    model_on = 1'b1;
    enable   = 1'b1;
    tick();
    n = cyc;
    wr_en = 1'b1; wr_data = 8'h7A;
    tick();
    wr_en = 1'b0;
    checks++; if (level !== 4'd1 || tx_start !== 1'b0) begin failures++; $display("FAIL single_n1 got level=%0d start=%b exp 1 0", level, tx_start); end
    tick();
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h7A) begin failures++; $display("FAIL single_n2 got start=%b data=%h exp 1 7a", tx_start, tx_data); end
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL single_level_pop got=%0d exp=0", level); end
    for (int i = 0; i < 60 && done_cyc.size() < 1; i++) tick();
    checks++; if (done_cyc.size() != 1) begin failures++; $display("FAIL single_done_wait got=%0d exp=1", done_cyc.size()); end
    checks++; if (start_cyc.size() != 1 || start_cyc[0] != n + 2) begin failures++; $display("FAIL single_start_cycle got=%0d exp=%0d", (start_cyc.size() > 0) ? start_cyc[0] - n : -1, 2); end
    checks++; if (start_fall != busy_rise + 1) begin failures++; $display("FAIL single_start_fall got=%0d exp=%0d", start_fall, busy_rise + 1); end
    tick();
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL single_idle got=%b exp=1", idle); end
  endtask

  task automatic test_burst();
    int e;
    clear_log();
    enable = 1'b0;
    tick();
    wr_en = 1'b1; wr_data = 8'hAA;
    tick();
    checks++; if (level !== 4'd1) begin failures++; $display("FAIL burst_level1 got=%0d exp=1", level); end
    wr_data = 8'h19;
    tick();
    checks++; if (level !== 4'd2) begin failures++; $display("FAIL burst_level2 got=%0d exp=2", level); end
    wr_data = 8'hE5;
    tick();
    wr_en = 1'b0;
    checks++; if (level !== 4'd3) begin failures++; $display("FAIL burst_level3 got=%0d exp=3", level); end
    e = cyc;
    enable = 1'b1;
    for (int i = 0; i < 200 && done_cyc.size() < 3; i++) tick();
    checks++; if (done_cyc.size() != 3 || start_cyc.size() != 3) begin failures++; $display("FAIL burst_count got starts=%0d dones=%0d exp 3 3", start_cyc.size(), done_cyc.size()); end
    else begin
      checks++; if (start_data[0] !== 8'hAA || start_data[1] !== 8'h19 || start_data[2] !== 8'hE5) begin failures++; $display("FAIL burst_order got=%h %h %h exp=aa 19 e5", start_data[0], start_data[1], start_data[2]); end
      checks++; if (start_cyc[0] != e + 1) begin failures++; $display("FAIL burst_first_start got=%0d exp=%0d", start_cyc[0] - e, 1); end
      checks++; if (start_cyc[1] != done_cyc[0] + 2 || start_cyc[2] != done_cyc[1] + 2) begin failures++; $display("FAIL burst_gap got=%0d %0d exp=2 2", start_cyc[1] - done_cyc[0], start_cyc[2] - done_cyc[1]); end
      checks++; if (start_level[0] != 2 || start_level[1] != 1 || start_level[2] != 0) begin failures++; $display("FAIL burst_level_dec got=%0d %0d %0d exp=2 1 0", start_level[0], start_level[1], start_level[2]); end
    end
    tick();
  endtask

  task automatic test_overflow();
    bit ok;
    clear_log();
    enable = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      tick();
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
    end
    tick();
    wr_en = 1'b0;
    checks++; if (full !== 1'b1 || level !== 4'd8 || empty !== 1'b0) begin failures++; $display("FAIL ovf_full got full=%b level=%0d empty=%b exp 1 8 0", full, level, empty); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    clr_status = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    clr_status = 1'b0; wr_en = 1'b0;
    checks++; if (overflow !== 1'b1 || level !== 4'd8) begin failures++; $display("FAIL ovf_clr_vs_event got ovf=%b level=%0d exp 1 8", overflow, level); end
    enable = 1'b1;
    for (int i = 0; i < 400 && done_cyc.size() < DEPTH; i++) tick();
    tick(); tick(); tick();
    checks++; if (start_cyc.size() != DEPTH || idle !== 1'b1) begin failures++; $display("FAIL ovf_frames got starts=%0d idle=%b exp %0d 1", start_cyc.size(), idle, DEPTH); end
    ok = (start_data.size() == DEPTH);
    for (int i = 0; i < start_data.size(); i++) if (start_data[i] !== 8'h10 + 8'(i)) ok = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL ovf_data got first=%h last=%h exp 10..17", start_data[0], start_data[start_data.size()-1]); end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_enable_gating();
    bit stray;
    clear_log();
    enable = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 8'h55;
    tick();
    wr_data = 8'h66;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 20 && tx_busy !== 1'b1; i++) tick();
    enable = 1'b0;
    tick();
    checks++; if (tx_enable !== 1'b1 || tx_busy !== 1'b1) begin failures++; $display("FAIL gate_txen_send got txen=%b busy=%b exp 1 1", tx_enable, tx_busy); end
    for (int i = 0; i < 40 && done_cyc.size() < 1; i++) tick();
    tick();
    checks++; if (tx_enable !== 1'b0 || idle !== 1'b0 || level !== 4'd1) begin failures++; $display("FAIL gate_after_done got txen=%b idle=%b level=%0d exp 0 0 1", tx_enable, idle, level); end
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_start !== 1'b0) stray = 1'b1;
    end
    checks++; if (stray || start_cyc.size() != 1) begin failures++; $display("FAIL gate_no_launch got starts=%0d exp=1", start_cyc.size()); end
    enable = 1'b1;
    for (int i = 0; i < 60 && done_cyc.size() < 2; i++) tick();
    checks++; if (start_data.size() != 2 || start_data[1] !== 8'h66) begin failures++; $display("FAIL gate_resume got starts=%0d exp=2 data 66", start_data.size()); end
    tick(); tick();
  endtask

  task automatic test_timeout();
    bit held;
    clear_log();
    model_on = 1'b0;
    enable   = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 10 && tx_start !== 1'b1; i++) tick();
    checks++; if (tx_start !== 1'b1 || level !== 4'd0) begin failures++; $display("FAIL to_request got start=%b level=%0d exp 1 0", tx_start, level); end
`ifdef UART_TX_CTRL_TIMEOUT_EN
    for (int i = 0; i < ACK_TO + 20 && tx_start !== 1'b0; i++) tick();
    checks++; if (tx_start !== 1'b0 || timeout_err !== 1'b1 || level !== 4'd0) begin failures++; $display("FAIL to_expire got start=%b err=%b level=%0d exp 0 1 0", tx_start, timeout_err, level); end
    checks++; if (start_cyc.size() != 1 || start_fall - start_cyc[0] != ACK_TO) begin failures++; $display("FAIL to_duration got=%0d exp=%0d", start_fall - start_cyc[0], ACK_TO); end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    checks++; if (timeout_err !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL to_clear got err=%b idle=%b exp 0 1", timeout_err, idle); end
`else
    held = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx_start !== 1'b1 || timeout_err !== 1'b0) held = 1'b0;
    end
    checks++; if (!held) begin failures++; $display("FAIL to_hold got start=%b err=%b exp 1 0", tx_start, timeout_err); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    bit stray;
    do_reset();
    model_on = 1'b0;
    enable   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      wr_en = 1'b1; wr_data = 8'hA1 + 8'(i);
    end
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 10 && tx_start !== 1'b1; i++) tick();
    checks++; if (tx_start !== 1'b1 || level !== 4'd3) begin failures++; $display("FAIL rst_pre got start=%b level=%0d exp 1 3", tx_start, level); end
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b0 || tx_data !== 8'h00 || level !== 4'd0) begin failures++; $display("FAIL rst_async_data got start=%b data=%h level=%0d exp 0 00 0", tx_start, tx_data, level); end
    checks++; if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rst_async_flags got e=%b f=%b o=%b t=%b exp 1 0 0 0", empty, full, overflow, timeout_err); end
    checks++; if (tx_enable !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL rst_async_state got txen=%b idle=%b exp 0 1", tx_enable, idle); end
    tick();
    tick();
    rst_n = 1'b1;
    clear_log();
    enable = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_start !== 1'b0) stray = 1'b1;
    end
    checks++; if (stray || start_cyc.size() != 0 || idle !== 1'b1) begin failures++; $display("FAIL rst_no_launch got starts=%0d idle=%b exp 0 1", start_cyc.size(), idle); end
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    clr_status = 1'b0;
    tx_busy    = 1'b0;
    tx_done    = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_enable_gating();
    test_timeout();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Byte-queueing sequencer for the UART `transmitter`. It buffers bytes written by the APB-side register logic in a small synchronous FIFO. It launches one frame at a time into the transmitter through a start/busy/done handshake and never issues a start while a frame is in flight. It sits between the APB UART register slice and `transmitter`, and runs on the system clock.

## Interface
Parameters:
- `DEPTH`, 8: FIFO depth in bytes; power of two, minimum 2.
- `ACK_TIMEOUT`, 4096: clk cycles to wait for `tx_busy` after raising `tx_start`. Must exceed one baud period (about 1042 at 10 MHz / 9600).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  launch enable; while low, no new frame starts.
- `wr_en`  in  1  push strobe; one byte per cycle.
- `wr_data`  in  8  byte to queue.
- `full`  out  1  FIFO holds DEPTH bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; set when a push is dropped.
- `clr_status`  in  1  single-cycle pulse; clears `overflow` and `timeout_err`.
- `tx_start`  out  1  frame request to transmitter.
- `tx_enable`  out  1  transmitter enable.
- `tx_data`  out  8  byte presented to transmitter; stable while `tx_start` is high.
- `tx_busy`  in  1  transmitter frame in progress; serves as start acknowledge.
- `tx_done`  in  1  end-of-frame indication, at least 1 clk wide.
- `idle`  out  1  high when state is IDLE and the FIFO is empty.
- `timeout_err`  out  1  sticky acknowledge-timeout flag.

## Operation
- FSM states: IDLE, REQ, SEND.
  - IDLE → REQ when `enable && !empty && !tx_busy`. On this transition the FIFO head is popped into the `tx_data` register and `tx_start` is set to 1.
  - REQ → SEND when `tx_busy`=1. `tx_start` is cleared.
  - SEND → IDLE when `tx_done`=1.
- `tx_enable` = `enable` OR (state ≠ IDLE). Dropping `enable` mid-frame never truncates a frame.
- Push acceptance: `wr_en && (!full || pop)`. A push and a pop in the same cycle leave `level` unchanged.
- A push while full with no pop is dropped and sets `overflow`. FIFO contents are unchanged.
- A push into an empty FIFO is not popped in the same cycle; the launch decision uses registered `empty`.
- FIFO order is strictly first-in first-out. Pointers wrap modulo DEPTH, with one extra bit to distinguish full from empty.
- If `clr_status` and a new error event occur in the same cycle, the new event wins and the flag stays 1.
- Reset values: all state is cleared asynchronously and FIFO contents are discarded.
  - `tx_start`=0, `tx_data`=0x00, state=IDLE, `level`=0.
  - `empty`=1, `full`=0, `overflow`=0, `timeout_err`=0.
  - `tx_enable`=0, `idle`=1.

## Timing
- All outputs are registered except `tx_enable`, `idle`, `full` and `empty`, which decode from registers.
- `wr_en` in cycle N (idle, enabled, `tx_busy`=0):
  - `level` increments at N+1.
  - `tx_start`=1 with valid `tx_data` from N+2.
- `tx_busy` first high in cycle M: `tx_start` is low from M+1.
- `tx_done` high in cycle K: state is IDLE at K+1. The next `tx_start` rises at K+2 if the FIFO is non-empty.
- Back-to-back frames therefore have a 2-cycle controller overhead after `tx_done`.

## Configuration
Macro `UART_TX_CTRL_TIMEOUT_EN`:
- **Defined:** a counter runs in REQ and resets on entry to REQ.
  - If it reaches ACK_TIMEOUT−1 without `tx_busy`, the FSM returns to IDLE, the popped byte is discarded, `tx_start` drops, and `timeout_err` is set.
- **Undefined:** REQ waits indefinitely, no counter is instantiated, and `timeout_err` is tied to 0.

## Structure
- Shared package `uart_pkg` holds:
  - the `DATA_W`=8 constant;
  - the `uart_tx_ctrl_state_t` enum (IDLE, REQ, SEND);
  - the default ACK_TIMEOUT constant.
- One sub-module, `uart_tx_fifo`: a synchronous FIFO with `DEPTH` parameter, push/pop, full/empty/level, and a registered head. The FSM and handshake logic stay in `uart_tx_ctrl`.

## Test plan
- Single byte: push 0x7A while idle and enabled; transmitter model asserts busy 3 cycles after start, done 20 cycles later.
  → `tx_start` rises at N+2 with `tx_data`=0x7A and falls the cycle after busy; `idle`=1 after done.
- Burst: push 0xAA, 0x19, 0xE5 on consecutive cycles.
  → Three frames in that order; each `tx_start` rises exactly 2 cycles after the previous `tx_done`; `level` goes 1, 2, 3, then decrements on each launch.
- Overflow: with `enable`=0, push DEPTH+1 bytes.
  → `full`=1 and `overflow`=1; the last byte is dropped; after `enable`=1, exactly DEPTH frames are sent. `clr_status` clears `overflow`.
- Enable gating: drop `enable` during SEND.
  → The current frame completes and `tx_enable` stays 1 until IDLE; no new launch occurs until `enable`=1.
- Timeout (macro defined): never assert `tx_busy`.
  → After ACK_TIMEOUT cycles, `tx_start`=0, `timeout_err`=1, and `level` is reduced by 1.
  - With the macro undefined, `tx_start` stays high indefinitely.
- Reset mid-frame: assert `rst_n`=0 during REQ with 3 bytes queued.
  → All outputs take their reset values immediately, with no clock edge needed; after release, no frame launches.
